tv80_alu16_seq: RTL

- Multi-cycle sequencer that runs 16-bit ADD/ADC/SBC/SUB (ADD HL,ss; ADC/SBC HL,ss) on the 8-bit combinational ALU.
- Sits directly upstream of the ALU: drives its operand, opcode, Arith16, Z16 and flag inputs.
- Consumes the ALU's Q and F_Out and assembles a 16-bit result and final flag byte.
- Handshakes with the microcode/control stage on both request and response sides.

---
 rtl/tv80_alu16_seq_if.sv | 37 +++
 rtl/tv80_alu16_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/tv80_alu16_seq_if.sv
// Bundle of the request, response and ALU-side signals of the 16-bit ALU sequencer.
// slave = the sequencer itself; master = control stage plus the 8-bit ALU.
interface tv80_alu16_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_f;

  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [7:0]  alu_f_in;
  logic [7:0]  alu_q;
  logic [7:0]  alu_f_out;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_flags;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_f, alu_q, alu_f_out, rsp_ready,
    output req_ready, alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in,
           rsp_valid, rsp_result, rsp_flags, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_f, alu_q, alu_f_out, rsp_ready,
    input  req_ready, alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in,
           rsp_valid, rsp_result, rsp_flags, busy
  );
endinterface

// File: rtl/tv80_alu16_seq.sv
// Runs 16-bit ADD/ADC/SBC/SUB as two passes (low byte, then high byte) through the 8-bit ALU.
// Define TV80_ALU16_PIPE_EN to accept the next request in the same cycle a response retires.
module tv80_alu16_seq #(
  parameter int unsigned FLAG_C = 0,
  parameter int unsigned FLAG_H = 4
) (
  input logic             clk,
  input logic             reset,
  tv80_alu16_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam logic [1:0] OpAdd16 = 2'b00;
  localparam logic [1:0] OpAdc16 = 2'b01;
  localparam logic [1:0] OpSbc16 = 2'b10;
  localparam logic [1:0] OpSub16 = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  f_q, tmp_f_q, flags_q;
  logic [15:0] result_q;
  logic        accept;

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = StLo;
        end
      end
      StLo:   state_d = StHi;
      StHi:   state_d = StDone;
      StDone: begin
`ifdef TV80_ALU16_PIPE_EN
        bus.req_ready = bus.rsp_ready;
        if (bus.rsp_ready) begin
          if (bus.req_valid) begin
            accept  = 1'b1;
            state_d = StLo;
          end else begin
            state_d = StIdle;
          end
        end
`else
        if (bus.rsp_ready) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // DONE keeps driving the high-byte pass so the ALU inputs stay quiet until retire.
  always_comb begin
    bus.alu_op      = 4'b0000;
    bus.alu_arith16 = 1'b0;
    bus.alu_z16     = 1'b0;
    bus.alu_busa    = 8'h00;
    bus.alu_busb    = 8'h00;
    bus.alu_f_in    = 8'h00;
    if (state_q == StLo) begin
      bus.alu_busa    = a_q[7:0];
      bus.alu_busb    = b_q[7:0];
      bus.alu_f_in    = f_q;
      bus.alu_arith16 = (op_q == OpAdd16);
      unique case (op_q)
        OpAdd16: bus.alu_op = 4'b0000;
        OpAdc16: bus.alu_op = 4'b0001;
        OpSbc16: bus.alu_op = 4'b0011;
        OpSub16: bus.alu_op = 4'b0010;
      endcase
    end else if (state_q == StHi || state_q == StDone) begin
      // Carry-using ops chain the low-byte carry; Z16 folds in the low-byte Z.
      bus.alu_busa    = a_q[15:8];
      bus.alu_busb    = b_q[15:8];
      bus.alu_f_in    = tmp_f_q;
      bus.alu_op      = op_q[1] ? 4'b0011 : 4'b0001;
      bus.alu_arith16 = (op_q == OpAdd16);
      bus.alu_z16     = (op_q != OpAdd16);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      f_q      <= 8'h00;
      tmp_f_q  <= 8'h00;
      flags_q  <= 8'h00;
      result_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.req_op;
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
        f_q  <= bus.req_f;
      end
      if (state_q == StLo) begin
        result_q[7:0] <= bus.alu_q;
        tmp_f_q       <= bus.alu_f_out;
      end
      if (state_q == StHi) begin
        result_q[15:8] <= bus.alu_q;
        flags_q        <= bus.alu_f_out;
      end
    end
  end

  assign bus.rsp_valid  = (state_q == StDone);
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.busy       = (state_q != StIdle);

  flag_index_ok: assert property (@(posedge clk)
    (FLAG_C < 8) && (FLAG_H < 8) && (FLAG_C != FLAG_H));

endmodule
